// File: rtl/nn_pkg.sv
// Shared widths, FSM state encoding and vector typedefs for the hidden-layer
// sequencer and the neuron datapath it feeds.
package nn_pkg;

    localparam int DATA_W     = 10;
    localparam int NUM_INPUTS = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EVAL  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } hl_state_t;

    typedef logic        [DATA_W-1:0] word_t;
    typedef logic signed [DATA_W-1:0] sword_t;

    typedef word_t  [NUM_INPUTS-1:0] vec_t;
    typedef sword_t [NUM_INPUTS-1:0] svec_t;

endpackage

// File: rtl/hidden_layer_sequencer.sv
// Time-multiplexes one shared neuron datapath over NUM_NEURONS hidden units:
// fetch weight row, load neuron operands, capture activation, stream result.
module hidden_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  vec_t             in_vec,
    input  logic             abort,
    output logic             busy,
    output logic             w_rd_en,
    output logic [IDX_W-1:0] w_addr,
    input  svec_t            w_rdata,
    output vec_t             nrn_in,
    output svec_t            nrn_weight,
    input  word_t            nrn_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output word_t            out_data,
    output logic             done
);

    hl_state_t        state;
    vec_t             in_q;
    logic [IDX_W-1:0] idx;
    logic             last;

    assign last = (idx == IDX_W'(NUM_NEURONS - 1));

    // Control outputs decode straight from the state register so an
    // asynchronous reset or abort clears them without a cycle of lag.
    assign busy      = (state != IDLE);
    assign w_rd_en   = (state == FETCH);
    assign w_addr    = idx;
    assign out_valid = (state == EMIT);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_q       <= '0;
            idx        <= '0;
            nrn_in     <= '0;
            nrn_weight <= '0;
            out_idx    <= '0;
            out_data   <= '0;
        end else if (abort) begin
            // Data registers deliberately keep their contents on abort.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_q  <= in_vec;
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    // Weight memory returns the row one cycle after the strobe.
                    nrn_weight <= w_rdata;
                    nrn_in     <= in_q;
                    state      <= EVAL;
                end
                EVAL: begin
                    out_data <= nrn_out;
                    out_idx  <= idx;
                    state    <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hidden_layer_sequencer.md
# hidden_layer_sequencer

Time-multiplexes one shared hidden-neuron datapath (10 inputs × 10 signed weights → multiply, sum, activation) across `NUM_NEURONS` hidden units. For each unit it fetches the weight row from an external weight memory, presents the latched input vector and that row to the neuron instance, and captures the activation result. Each result is streamed out with a valid/ready handshake. The block sits between the input-vector source and the output-layer logic; the neuron instance itself lives in the parent.

## Interface

Parameters:
- `NUM_NEURONS`, 8: hidden units evaluated per run; must be ≥ 1.
- `IDX_W`, `$clog2(NUM_NEURONS)` (minimum 1): width of unit index and weight address.

Ports (from `nn_pkg`: `DATA_W` = 10, `NUM_INPUTS` = 10):
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `in_vec[0:9]` in 10 each (unsigned): input vector; latched on an accepted `start`.
- `abort` in 1: synchronous; returns the FSM to IDLE on the next edge from any state.
- `busy` out 1: high in every state except IDLE.
- `w_rd_en` out 1: weight-memory read strobe.
- `w_addr` out `IDX_W`: weight row address, equal to the current unit index.
- `w_rdata[0:9]` in 10 each (signed): weight row; valid exactly 1 cycle after `w_rd_en`.
- `nrn_in[0:9]` out 10 each: to the neuron instance; registered.
- `nrn_weight[0:9]` out 10 each (signed): to the neuron instance; registered.
- `nrn_out` in 10: neuron activation output, combinational from `nrn_in` and `nrn_weight`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_idx` out `IDX_W`: unit index of the current result.
- `out_data` out 10: activation result.
- `done` out 1: one-cycle pulse after the last result is accepted.

## Operation

- FSM states: IDLE → FETCH → LOAD → EVAL → EMIT → (FETCH | DONE) → IDLE.
- IDLE: `start`=1 latches `in_vec` into `in_q`, sets `idx`=0, goes to FETCH. `start` in any other state is ignored.
- FETCH (1 cycle): `w_rd_en`=1, `w_addr`=`idx`.
- LOAD (1 cycle): registers `w_rdata` into `nrn_weight`; `nrn_in` is driven from `in_q`.
- EVAL (1 cycle): `nrn_in` and `nrn_weight` are stable; `nrn_out` is captured into `out_data` and `idx` into `out_idx` at the end of the cycle.
- EMIT: `out_valid`=1. `out_data` and `out_idx` hold until `out_valid && out_ready`.
- On that handshake: if `idx` == `NUM_NEURONS`-1, go to DONE; otherwise `idx`+1 and go to FETCH.
- DONE (1 cycle): `done`=1, then IDLE.
- `nrn_in` and `nrn_weight` keep their last values outside LOAD/EVAL; `nrn_weight` changes only in LOAD.
- `abort` has priority over every transition. It clears `out_valid` and suppresses `done`; data registers keep their values.
- `idx` never wraps within a run; a new run restarts at 0.

## Timing

- Reset values (asynchronous): state IDLE; `busy`, `w_rd_en`, `out_valid`, `done` = 0; `w_addr`, `out_idx`, `idx` = 0; `out_data`, all `nrn_in`, all `nrn_weight` = 0.
- Reset asserted mid-run: outputs reach reset values immediately; no `done` is produced for that run.
- With `out_ready` held high: `start` accepted at edge 0, `busy` rises at edge 1, first `out_valid` at edge 4, each later result 4 cycles after the previous one.
- `done` appears in the cycle after the final handshake; run length is 4·`NUM_NEURONS`+1 cycles.
- Each cycle of `out_ready`=0 in EMIT adds one cycle; the outputs are stable throughout.
- `start` in the same cycle that DONE returns to IDLE is not seen; `start` is accepted one cycle later at the earliest.

## Structure

- `nn_pkg` holds `DATA_W`, `NUM_INPUTS`, the state enum `hl_state_t` (IDLE, FETCH, LOAD, EVAL, EMIT, DONE), and the array typedefs `vec_t` / `svec_t`.
- Single flat module with no sub-module. The neuron and the weight memory are instantiated by the parent.

## Test plan

- Reset/idle: hold `rst_n`=0, then release with no `start` → all outputs 0, `busy`=0 for 20 cycles.
- Basic run: `NUM_NEURONS`=3, weight rows with `w[0]` = 5, 6, 7, bench neuron model `nrn_out` = `nrn_weight[0]`+100, `out_ready`=1 → results (idx, data) = (0,105), (1,106), (2,107) at cycles 4, 8, 12; `done` at cycle 13.
- Backpressure: same run with `out_ready`=0 for 5 cycles on unit 1 → `out_data`=106 and `out_idx`=1 held for 5 cycles; `done` at cycle 18.
- Input latch: change `in_vec` from all 3 to all 9 one cycle after `start` → `nrn_in` remains 3 for the whole run.
- Abort/ignored start: assert `abort` in unit 1's EVAL → next cycle IDLE, `out_valid`=0, no `done`; `start` pulsed while `busy` earlier does not restart the run.
- Async reset mid-EMIT: drop `rst_n` between clock edges → `out_valid`=0 immediately; a fresh `start` yields idx 0 first.
